// File: rtl/alu_seq.sv
// Purpose: control sequencer for one register-register ALU instruction on a single shared bus.
// Latency: start-sampling cycle to done-high cycle is 4 (binary), 3 (unary), 5 (wide mul/div).
// Backpressure: none; start is only sampled in IDLE, and a start seen while busy is dropped.
module alu_seq (
    input  logic        Clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    output logic        busy,
    output logic        done,
    output logic [4:0]  op,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        Yin,
    output logic        ZHighin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_Y = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB_LO  = 3'd3;
    localparam logic [2:0] S_WB_HI  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;
    localparam logic [4:0] OP_NOP = 5'b00000;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [4:0]  r_opcode;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [3:0]  r_rc;

    logic        w_accept;
    logic        w_unary_in;
    logic        w_wide;
    logic [15:0] w_ra_sel;
    logic [15:0] w_rb_sel;
    logic [15:0] w_rc_sel;

    // A new instruction is only taken from IDLE; unary-ness is judged on the incoming opcode
    // because it decides the very first transition.
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_unary_in = (opcode == OP_NEG) || (opcode == OP_NOT);
    // Wide results (mul/div) are 32 bits and go to LO/HI rather than to the register file.
    assign w_wide     = (r_opcode == OP_MUL) || (r_opcode == OP_DIV);

    // One-hot register selects from the latched indices; shifting a single 1 keeps them one-hot
    // by construction, so ra/rb/rc aliasing each other needs no special handling.
    assign w_ra_sel = 16'h0001 << r_ra;
    assign w_rb_sel = 16'h0001 << r_rb;
    assign w_rc_sel = 16'h0001 << r_rc;

    // State register and instruction-field latch; clear wins over everything, including start.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_opcode <= 5'd0;
            r_ra     <= 4'd0;
            r_rb     <= 4'd0;
            r_rc     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_opcode <= opcode;
                r_ra     <= ra;
                r_rb     <= rb;
                r_rc     <= rc;
            end
        end
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_unary_in ? S_EXEC : S_LOAD_Y;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD_Y: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = S_WB_LO;
            S_WB_LO:  w_state_nxt = w_wide ? S_WB_HI : S_DONE;
            S_WB_HI:  w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode; each state drives at most one bus source, and IDLE drives nothing.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        op       = OP_NOP;
        Rout     = 16'h0000;
        Rin      = 16'h0000;
        Yin      = 1'b0;
        ZHighin  = 1'b0;
        Zlowin   = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD_Y: begin
                busy = 1'b1;
                Rout = w_rb_sel;
                Yin  = 1'b1;
            end
            S_EXEC: begin
                busy    = 1'b1;
                Rout    = w_rc_sel;
                op      = r_opcode;
                ZHighin = 1'b1;
                Zlowin  = 1'b1;
            end
            S_WB_LO: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (w_wide) begin
                    LOin = 1'b1;
                end else begin
                    Rin = w_ra_sel;
                end
            end
            S_WB_HI: begin
                busy     = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have exactly one clock, Clock, and its reset, clear, SHALL be synchronous and active-high.
REQ-002 The ports SHALL be as follows:
- Clock  in  1  system clock; all state changes on rising edge
- clear  in  1  synchronous active-high reset
- start  in  1  request to run one register-register ALU instruction
- opcode  in  5  ALU operation code; passed to the datapath op input
- ra  in  4  destination register index
- rb  in  4  first source register index; loaded into Y
- rc  in  4  second source register index; driven on bus during execute
- busy  out  1  high while an instruction is in progress
- done  out  1  one-cycle completion pulse
- op  out  5  ALU operation select to datapath
- Rout  out  16  one-hot register-to-bus enable; bit n = Rn
- Rin  out  16  one-hot bus-to-register load enable; bit n = Rn
- Yin  out  1  Y register load
- ZHighin  out  1  Z high half load
- Zlowin  out  1  Z low half load
- Zlowout  out  1  Z low half to bus
- Zhighout  out  1  Z high half to bus
- LOin  out  1  LO register load
- HIin  out  1  HI register load

Function
REQ-003 States SHALL be IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE; all outputs SHALL be Moore, decoded from state and the latched fields.
REQ-004 In IDLE with start=1, opcode/ra/rb/rc SHALL be latched at that edge; inputs SHALL be ignored at all other times.
REQ-005 Opcodes 5'b10001 (neg) and 5'b10010 (not) SHALL be unary: IDLE->EXEC, skipping LOAD_Y; all other opcodes: IDLE->LOAD_Y.
REQ-006 LOAD_Y: Rout[rb]=1, Yin=1; next state EXEC.
REQ-007 EXEC: Rout[rc]=1, op=latched opcode, ZHighin=1, Zlowin=1; next state WB_LO.
REQ-008 op SHALL be 5'b00000 in every state except EXEC.
REQ-009 Opcodes 5'b01111 (mul) and 5'b10000 (div) SHALL be wide: WB_LO drives Zlowout=1, LOin=1, next state WB_HI; WB_HI drives Zhighout=1, HIin=1, next state DONE.
REQ-010 Non-wide: WB_LO drives Zlowout=1, Rin[ra]=1; next state DONE; Rin SHALL never assert for wide opcodes.
REQ-011 DONE: done=1 for exactly one cycle, no other control asserted; next state IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE; start while busy SHALL be dropped, not queued.
REQ-013 At most one bit of Rout and at most one bit of Rin SHALL be high in any cycle; at most one bus driver (Rout bit, Zlowout, Zhighout) SHALL be active per cycle.
REQ-014 rb=rc, ra=rb, and ra=0 SHALL be legal and handled without special cases.
REQ-015 Latency, counted from the start-sampling edge to the done-high cycle: binary 4 cycles, unary 3, wide binary 5.
REQ-016 Back-to-back: start high in the cycle following DONE (state IDLE) SHALL be accepted.

Reset
REQ-017 clear=1 at a rising edge SHALL force IDLE and clear the latched fields to 0; from that edge all outputs SHALL be 0, including mid-instruction (no partial writeback after clear).
REQ-018 clear SHALL take priority over start in the same cycle.

Verification
REQ-019 Binary rol: opcode=5'b00110, rb=3, rc=2, ra=1 -> LOAD_Y Rout=16'h0008 with Yin; EXEC Rout=16'h0004, op=6, ZHighin=Zlowin=1; WB_LO Zlowout=1, Rin=16'h0002; done on cycle 4.
REQ-020 Unary not: opcode=5'b10010, rc=5, ra=7 -> no Yin cycle; EXEC Rout=16'h0020; WB_LO Rin=16'h0080; done on cycle 3.
REQ-021 mul: opcode=5'b01111, rb=4, rc=6 -> WB_LO Zlowout+LOin, WB_HI Zhighout+HIin, Rin stays 0; done on cycle 5.
REQ-022 start held high for 10 cycles with a binary op -> two instructions complete, done pulses 5 cycles apart, no extra starts latched mid-op.
REQ-023 clear asserted during EXEC -> next cycle all outputs 0, busy=0, no Rin/LOin/HIin ever asserts for that instruction.
REQ-024 clear and start both high in IDLE -> state stays IDLE, busy stays 0.
